// File: rtl/ascon_cmd_dispatch_pkg.sv
// Shared configuration for the Ascon command front-end.
// Holds the bus widths, the host opcode and bdi segment-type encodings,
// the dispatcher state type, and small decode helpers.
package ascon_cmd_dispatch_pkg;

  // Core bus widths. The dispatcher only supports 32-bit buses.
  localparam int CCW_DEF  = 32;
  localparam int CCSW_DEF = 32;

  // Host instruction opcodes, carried in instruction word bits [31:28].
  localparam logic [3:0] OP_DO_ENC   = 4'h1;
  localparam logic [3:0] OP_DO_DEC   = 4'h2;
  localparam logic [3:0] OP_DO_HASH  = 4'h3;
  localparam logic [3:0] OP_LD_KEY   = 4'h4;
  localparam logic [3:0] OP_LD_NONCE = 4'h5;
  localparam logic [3:0] OP_LD_AD    = 4'h6;
  localparam logic [3:0] OP_LD_PT    = 4'h7;
  localparam logic [3:0] OP_LD_CT    = 4'h8;
  localparam logic [3:0] OP_LD_TAG   = 4'h9;

  // Segment types understood by the core on bdi_type / bdo_type.
  localparam logic [3:0] D_NULL  = 4'h0;
  localparam logic [3:0] D_NONCE = 4'h1;
  localparam logic [3:0] D_AD    = 4'h2;
  localparam logic [3:0] D_PTCT  = 4'h3;
  localparam logic [3:0] D_TAG   = 4'h4;

  // Dispatcher FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_BDI  = 2'd2
  } cmd_state_t;

  // Byte length to 32-bit word count. The sum is formed in 25 bits so the
  // largest length (0xFFFFFF) yields 0x400000 rather than wrapping to 0.
  function automatic logic [22:0] word_count(input logic [23:0] len);
    logic [24:0] sum;
    sum = {1'b0, len} + 25'd3;
    return sum[24:2];
  endfunction

  // Segment type presented on bdi for a given load opcode.
  function automatic logic [3:0] bdi_type_of(input logic [3:0] op);
    logic [3:0] t;
    t = D_NULL;
    case (op)
      OP_LD_NONCE:        t = D_NONCE;
      OP_LD_AD:           t = D_AD;
      OP_LD_PT, OP_LD_CT: t = D_PTCT;
      OP_LD_TAG:          t = D_TAG;
      default:            t = D_NULL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ascon_cmd_dispatch_out_reg.sv
// One-entry registered slice between the core's bdo channel and the host
// output stream. Accepts a new word whenever the slot is empty or being
// drained this cycle, so a continuously ready host sees one word per cycle.
module ascon_out_reg
  import ascon_cmd_dispatch_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic [3:0]   in_type,
  input  logic         in_eot,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic [3:0]   out_type,
  output logic         out_eot,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] data_q, data_d;
  logic [3:0]   type_q, type_d;
  logic         eot_q, eot_d;
  logic         valid_q, valid_d;
  logic         capture;

  // Slot update: capture overwrites (even while draining), drain empties.
  always_comb begin
    in_ready = !valid_q || out_ready;
    capture  = in_valid && in_ready;
    data_d   = data_q;
    type_d   = type_q;
    eot_d    = eot_q;
    valid_d  = valid_q;
    if (capture) begin
      data_d  = in_data;
      type_d  = in_type;
      eot_d   = in_eot;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      type_q  <= D_NULL;
      eot_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      type_q  <= type_d;
      eot_q   <= eot_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_type  = type_q;
  assign out_eot   = eot_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/ascon_cmd_dispatch.sv
// Host command front-end for ascon_core. Decodes instruction words from a
// 32-bit host stream, steers the following data words onto the core's key
// or bdi channel with zero added latency, holds the decrypt/hash mode,
// registers bdo toward the host and latches the tag-verification result.
module ascon_cmd_dispatch
  import ascon_cmd_dispatch_pkg::*;
#(
  parameter int CCW  = CCW_DEF,
  parameter int CCSW = CCSW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     cmd_data,
  input  logic            cmd_hdr,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  output logic [CCSW-1:0] key,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [CCW-1:0]  bdi,
  output logic            bdi_valid,
  input  logic            bdi_ready,
  output logic [3:0]      bdi_type,
  output logic            bdi_eot,
  output logic            bdi_eoi,
  output logic            decrypt,
  output logic            hash,
  input  logic [CCW-1:0]  bdo,
  input  logic            bdo_valid,
  input  logic [3:0]      bdo_type,
  input  logic            bdo_eot,
  output logic            bdo_ready,
  input  logic            auth,
  input  logic            auth_valid,
  output logic            auth_ready,
  output logic [31:0]     out_data,
  output logic [3:0]      out_type,
  output logic            out_eot,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            ver_valid,
  output logic            ver_ok,
  output logic            err_proto
);

  if (CCW != 32 || CCSW != 32) begin : g_bad_width
    $error("ascon_cmd_dispatch: CCW and CCSW must both be 32");
  end

  cmd_state_t  state_q, state_d;
  logic [22:0] cnt_q, cnt_d;
  logic [3:0]  seg_type_q, seg_type_d;   // bdi_type for the open segment
  logic        seg_eoi_q, seg_eoi_d;     // flags[0] of the open segment
  logic        decrypt_q, decrypt_d;
  logic        hash_q, hash_d;
  logic        ver_valid_q, ver_valid_d;
  logic        ver_ok_q, ver_ok_d;
  logic        err_proto_q, err_proto_d;

  logic [3:0]  ins_op;
  logic [22:0] ins_nw;
  logic        last_beat;

  assign ins_op    = cmd_data[31:28];
  assign ins_nw    = word_count(cmd_data[23:0]);
  assign last_beat = (cnt_q == 23'd1);

  // Next-state, counters and combinational channel steering.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seg_type_d  = seg_type_q;
    seg_eoi_d   = seg_eoi_q;
    decrypt_d   = decrypt_q;
    hash_d      = hash_q;
    ver_valid_d = ver_valid_q;
    ver_ok_d    = ver_ok_q;
    err_proto_d = err_proto_q;
    cmd_ready   = 1'b0;
    key         = '0;
    key_valid   = 1'b0;
    bdi         = '0;
    bdi_valid   = 1'b0;
    bdi_type    = D_NULL;
    bdi_eot     = 1'b0;
    bdi_eoi     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_hdr) begin
            case (ins_op)
              OP_DO_ENC: begin
                decrypt_d = 1'b0;
                hash_d    = 1'b0;
              end
              OP_DO_DEC: begin
                decrypt_d = 1'b1;
                hash_d    = 1'b0;
              end
              OP_DO_HASH: begin
                decrypt_d = 1'b0;
                hash_d    = 1'b1;
              end
              OP_LD_KEY: begin
                cnt_d = ins_nw;
                if (ins_nw != '0) state_d = ST_KEY;
              end
              OP_LD_NONCE, OP_LD_AD, OP_LD_PT, OP_LD_CT, OP_LD_TAG: begin
                cnt_d      = ins_nw;
                seg_type_d = bdi_type_of(ins_op);
                seg_eoi_d  = cmd_data[24];
                if (ins_op == OP_LD_TAG) ver_valid_d = 1'b0;
                if (ins_nw != '0) state_d = ST_BDI;
              end
              default: ;
            endcase
          end else begin
            err_proto_d = 1'b1;
          end
        end
      end

      ST_KEY: begin
        key       = cmd_data;
        key_valid = cmd_valid && !cmd_hdr;
        cmd_ready = cmd_hdr ? 1'b1 : key_ready;
        if (cmd_valid && cmd_hdr) begin
          err_proto_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else if (cmd_valid && key_ready) begin
          cnt_d = cnt_q - 23'd1;
          if (last_beat) state_d = ST_IDLE;
        end
      end

      ST_BDI: begin
        bdi       = cmd_data;
        bdi_valid = cmd_valid && !cmd_hdr;
        bdi_type  = seg_type_q;
        bdi_eot   = last_beat;
        bdi_eoi   = last_beat && seg_eoi_q;
        cmd_ready = cmd_hdr ? 1'b1 : bdi_ready;
        if (cmd_valid && cmd_hdr) begin
          err_proto_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else if (cmd_valid && bdi_ready) begin
          cnt_d = cnt_q - 23'd1;
          if (last_beat) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A result from the core overrides the clear done by LD_TAG.
    if (auth_valid) begin
      ver_valid_d = 1'b1;
      ver_ok_d    = auth;
    end
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      seg_type_q  <= D_NULL;
      seg_eoi_q   <= 1'b0;
      decrypt_q   <= 1'b0;
      hash_q      <= 1'b0;
      ver_valid_q <= 1'b0;
      ver_ok_q    <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seg_type_q  <= seg_type_d;
      seg_eoi_q   <= seg_eoi_d;
      decrypt_q   <= decrypt_d;
      hash_q      <= hash_d;
      ver_valid_q <= ver_valid_d;
      ver_ok_q    <= ver_ok_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign decrypt    = decrypt_q;
  assign hash       = hash_q;
  assign ver_valid  = ver_valid_q;
  assign ver_ok     = ver_ok_q;
  assign err_proto  = err_proto_q;
  assign auth_ready = 1'b1;

  ascon_out_reg #(.W(32)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_data   (bdo),
    .in_type   (bdo_type),
    .in_eot    (bdo_eot),
    .in_valid  (bdo_valid),
    .in_ready  (bdo_ready),
    .out_data  (out_data),
    .out_type  (out_type),
    .out_eot   (out_eot),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule

// File: doc/ascon_cmd_dispatch.md
# ascon_cmd_dispatch

Synthesizable command front-end placed directly upstream of `ascon_core`. It consumes a 32-bit host word stream made of instruction words and data words, and drives the core's key, bdi, decrypt and hash inputs. It also registers the core's bdo output into a host output stream and latches the tag-verification result. It replaces file-driven stimulus with an on-chip host port (UART/AXI-stream bridge).

## Interface

Parameters:
- `CCW`: default from the config package, must be 32. bdi/bdo width.
- `CCSW`: default from the config package, must be 32. key width.
- Elaboration check: `$error` if `CCW` or `CCSW` is not 32.

Ports:
- Clocking and reset: reset rst, synchronous, active-high; clock clk.
- `cmd_data` in 32: host word.
- `cmd_hdr` in 1: 1 = instruction word, 0 = data word.
- `cmd_valid` in 1, `cmd_ready` out 1: host input handshake.
- `key` out CCSW, `key_valid` out 1, `key_ready` in 1: key channel to the core.
- `bdi` out CCW, `bdi_valid` out 1, `bdi_ready` in 1: block-data-in channel to the core.
- `bdi_type` out 4, `bdi_eot` out 1, `bdi_eoi` out 1: bdi qualifiers to the core.
- `decrypt` out 1, `hash` out 1: mode registers to the core.
- `bdo` in CCW, `bdo_valid` in 1, `bdo_type` in 4, `bdo_eot` in 1, `bdo_ready` out 1: block-data-out channel from the core.
- `auth` in 1, `auth_valid` in 1, `auth_ready` out 1: tag-verification result from the core.
- `out_data` out 32, `out_type` out 4, `out_eot` out 1, `out_valid` out 1, `out_ready` in 1: host output stream.
- `ver_valid` out 1, `ver_ok` out 1: latched verification result.
- `err_proto` out 1: sticky protocol-error flag.

## Operation

**Instruction word fields.**
- `op` = [31:28], `flags` = [27:24], `len` = [23:0] bytes.
- Word count: `nw = (len + 3) >> 2`, computed in 25 bits and stored in a 23-bit `cnt`.

**FSM states:** IDLE, KEY, BDI.

**IDLE**
- `cmd_ready` = 1.
- Instruction word, by `op`:
  - OP_DO_ENC: decrypt <= 0, hash <= 0.
  - OP_DO_DEC: decrypt <= 1, hash <= 0.
  - OP_DO_HASH: decrypt <= 0, hash <= 1.
  - OP_LD_KEY: load `cnt` = nw, go to KEY if nw != 0.
  - OP_LD_NONCE/AD/PT/CT/TAG: load `cnt` = nw, register `op` and `flags`, go to BDI if nw != 0.
  - OP_LD_TAG additionally clears `ver_valid`.
  - nw == 0: no beats are issued and the FSM stays in IDLE.
  - Unknown op: ignored.
- Data word: dropped and `err_proto` <= 1.

**KEY**
- `key` = `cmd_data`.
- `key_valid` = `cmd_valid & !cmd_hdr`.
- `cmd_ready` = `key_ready` for data words.

**BDI**
- `bdi` = `cmd_data`.
- `bdi_valid` = `cmd_valid & !cmd_hdr`.
- `cmd_ready` = `bdi_ready` for data words.
- `bdi_type` by op: NONCE→D_NONCE, AD→D_AD, PT/CT→D_PTCT, TAG→D_TAG.
- `bdi_eot` = (cnt == 1).
- `bdi_eoi` = (cnt == 1) & flags[0].

**Data beats (KEY and BDI).**
- Each accepted beat decrements `cnt`; the FSM returns to IDLE when a beat is accepted with cnt == 1.
- An instruction word arriving while in KEY or BDI: consumed (`cmd_ready` = 1), discarded, `err_proto` <= 1, FSM aborts to IDLE.

**Inactive outputs.** Outside KEY, `key_valid` = 0 and `key` = 0. Outside BDI, `bdi_valid` = 0, `bdi` = 0 and `bdi_type` = D_NULL.

**Output stage.**
- One-entry register.
- `bdo_ready` = `!out_valid | out_ready`.
- On a bdo handshake, `out_data`, `out_type` and `out_eot` are captured and `out_valid` <= 1.
- `out_valid` clears on `out_ready` when no new capture occurs in the same cycle.

**Verification latch.**
- `auth_ready` = 1 always.
- On `auth_valid`: `ver_valid` <= 1, `ver_ok` <= auth.

## Timing

- **Reset.** All registers clear: state IDLE, cnt 0, decrypt 0, hash 0, out_valid 0, ver_valid 0, ver_ok 0, err_proto 0.
  - Reset mid-segment abandons the remaining words.
  - The core is reset by the same rst.
- **Input path.** cmd→key/bdi is combinational, with zero added latency; ready propagates combinationally back to the host.
- **Mode registers.** decrypt/hash take effect the cycle after the DO_* instruction is accepted.
- **Output path.** 1-cycle latency from bdo handshake to `out_valid`. Full throughput (1 word/cycle) when `out_ready` is held high.
- **Simultaneous events.**
  - Capture and drain in the same cycle: the register is overwritten and `out_valid` stays 1.
  - `auth_valid` coincident with an LD_TAG instruction: the `auth_valid` set wins.
- **Counter.** `cnt` never wraps; len = 0xFFFFFF gives nw = 0x400000.

## Structure

- OP_* and D_* encodings stay in the shared config package. A new state enum `cmd_state_t` is added there.
- Sub-module: `ascon_out_reg`, the one-entry output register with the valid/ready rule above.

## Test plan

- **Key load.** INS {LD_KEY, len=16}, 4 DAT words, key_ready toggling 1/0 → exactly 4 key beats; `cmd_ready` mirrors key_ready; IDLE afterwards.
- **Segment framing.** INS {LD_AD, flags=0, len=5} + 2 words → bdi_type D_AD on both beats, bdi_eot only on the 2nd, bdi_eoi 0. Repeat with flags=1 → bdi_eoi 1 on the 2nd beat.
- **Full encrypt.** DO_ENC, key, nonce, AD, PT (len=8) → decrypt 0; two PT words reach the core; out stream shows 2 D_PTCT words then 4 D_TAG words matching the core output.
- **Decrypt with tag.** DO_DEC, LD_TAG len=16 with the correct tag → ver_valid 1, ver_ok 1. Corrupted tag → ver_ok 0.
- **Back-pressure.** Hold out_ready = 0 for 5 cycles during PT output → bdo_ready 0 after the first capture; no word lost or duplicated.
- **Protocol errors.** Data word in IDLE → err_proto 1. INS mid-segment (after 1 of 3 words) → abort to IDLE. rst mid-segment → all outputs return to reset values.
